// File: rtl/inport_in_interface_ctrl.sv
// Serial link receiver: shifts in one bit per cycle and hands a full flit to the input buffer.
// Latency: flit_valid rises on the edge that accepts the last bit whenever the output slot is free.
// Backpressure: a full assembly with a busy slot parks at ptr==flit_size and drops link_ready.
module inport_in_interface_ctrl #(
    parameter int flit_size                   = 8,
    parameter int floorplusone_log2_flit_size = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   link_valid,
    input  logic                                   link_sof,
    input  logic                                   link_bit,
    output logic                                   link_ready,
    output logic [flit_size-1:0]                   flit_out,
    output logic                                   flit_valid,
    input  logic                                   flit_ready,
    output logic [floorplusone_log2_flit_size-1:0] ptr,
    output logic                                   err_sof,
    output logic                                   err_nosof
);
    localparam int P = floorplusone_log2_flit_size;
    localparam logic [P-1:0] FULL = P'(flit_size);
    localparam logic [P-1:0] ONE  = P'(1);

    logic [flit_size-1:0] asm_q;
    logic [flit_size-1:0] asm_nxt;
    logic [flit_size-1:0] load_dat;
    logic [P-1:0]         ptr_nxt;
    logic [P-1:0]         new_ptr;
    logic [P-1:0]         idx;
    logic                 idle;
    logic                 recv;
    logic                 hold;
    logic                 accept;
    logic                 take;
    logic                 slot_free;
    logic                 load;
    logic                 err_sof_nxt;
    logic                 err_nosof_nxt;

    assign link_ready = (ptr != FULL);

    always_comb begin
        idle      = (ptr == '0);
        hold      = (ptr == FULL);
        recv      = !idle && !hold;
        accept    = link_valid && link_ready;
        slot_free = !flit_valid || flit_ready;
        // A bit without sof in IDLE has no frame to land in and is discarded.
        take      = accept && (link_sof || !idle);
        idx       = link_sof ? '0 : ptr;
        new_ptr   = link_sof ? ONE : ptr + ONE;

        asm_nxt = asm_q;
        for (int i = 0; i < flit_size; i++) begin
            if (i == int'(idx)) begin
                asm_nxt[i] = link_bit;
            end
        end

        ptr_nxt       = ptr;
        load          = 1'b0;
        load_dat      = asm_q;
        err_sof_nxt   = accept && link_sof && recv;
        err_nosof_nxt = accept && !link_sof && idle;

        if (hold) begin
            if (slot_free) begin
                load    = 1'b1;
                ptr_nxt = '0;
            end
        end else if (take) begin
            load_dat = asm_nxt;
            if (new_ptr == FULL) begin
                // Completing bit goes straight to the output when possible, so no bubble.
                if (slot_free) begin
                    load    = 1'b1;
                    ptr_nxt = '0;
                end else begin
                    ptr_nxt = FULL;
                end
            end else begin
                ptr_nxt = new_ptr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            asm_q      <= '0;
            flit_out   <= '0;
            flit_valid <= 1'b0;
            err_sof    <= 1'b0;
            err_nosof  <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            err_sof   <= err_sof_nxt;
            err_nosof <= err_nosof_nxt;
            if (take) begin
                asm_q <= asm_nxt;
            end
            if (load) begin
                flit_out   <= load_dat;
                flit_valid <= 1'b1;
            end else if (flit_ready) begin
                flit_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_inport_in_interface_ctrl.sv
// Bench for the link receiver: directed scenarios plus random traffic against a queue-based model.
module tb_inport_in_interface_ctrl;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lv = 1'b0, ls = 1'b0, lb = 1'b0, fr = 1'b1;
    logic         link_ready, flit_valid, err_sof, err_nosof;
    logic [N-1:0] flit_out;
    logic [2:0]   ptr;

    logic         l1v = 1'b0, l1s = 1'b0, l1b = 1'b0, f1r = 1'b1;
    logic         o1_rdy, o1_vld, o1_esof, o1_enosof;
    logic [0:0]   o1_out;
    logic [0:0]   o1_ptr;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    inport_in_interface_ctrl #(.flit_size(N), .floorplusone_log2_flit_size(3)) u0 (
        .clk(clk), .rst(rst_n), .link_valid(lv), .link_sof(ls), .link_bit(lb),
        .link_ready(link_ready), .flit_out(flit_out), .flit_valid(flit_valid),
        .flit_ready(fr), .ptr(ptr), .err_sof(err_sof), .err_nosof(err_nosof));

    inport_in_interface_ctrl #(.flit_size(1), .floorplusone_log2_flit_size(1)) u1 (
        .clk(clk), .rst(rst_n), .link_valid(l1v), .link_sof(l1s), .link_bit(l1b),
        .link_ready(o1_rdy), .flit_out(o1_out), .flit_valid(o1_vld),
        .flit_ready(f1r), .ptr(o1_ptr), .err_sof(o1_esof), .err_nosof(o1_enosof));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: the partial flit is just a list of received bits; a full list waits for the slot.
    bit         q[$];
    logic [N-1:0] m_out = '0;
    bit         m_vld = 0, m_esof = 0, m_enosof = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit sf, ld;
        logic [N-1:0] pk;
        if (!rst_n) begin
            q.delete();
            m_out = '0; m_vld = 0; m_esof = 0; m_enosof = 0;
        end else begin
            sf = !m_vld || fr;
            ld = 0;
            m_esof = 0;
            m_enosof = 0;
            if (q.size() == N) begin
                if (sf) ld = 1;
            end else if (lv) begin
                if (ls) begin
                    if (q.size() > 0) m_esof = 1;
                    q.delete();
                    q.push_back(lb);
                end else if (q.size() == 0) begin
                    m_enosof = 1;
                end else begin
                    q.push_back(lb);
                end
                if (q.size() == N && sf) ld = 1;
            end
            if (ld) begin
                pk = '0;
                for (int k = 0; k < N; k++) pk[k] = q[k];
                q.delete();
                m_out = pk;
                m_vld = 1;
            end else if (fr) begin
                m_vld = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("link_ready", link_ready, (q.size() != N));
            check("ptr", ptr, q.size());
            check("flit_valid", flit_valid, m_vld);
            check("flit_out", flit_out, m_out);
            check("err_sof", err_sof, m_esof);
            check("err_nosof", err_nosof, m_enosof);
        end
    end

    task automatic send(input logic s, input logic b);
        lv = 1'b1; ls = s; lb = b;
        @(posedge clk); #1;
        lv = 1'b0; ls = 1'b0;
    endtask

    task automatic idle();
        lv = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send1(input logic s, input logic b);
        l1v = 1'b1; l1s = s; l1b = b;
        @(posedge clk); #1;
        l1v = 1'b0; l1s = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ptr", ptr, 0);
        check("rst_link_ready", link_ready, 1);
        check("rst_flit_valid", flit_valid, 0);
        check("rst_flit_out", flit_out, 0);
        check("rst_errs", {err_sof, err_nosof}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Back-to-back flits with the buffer always ready
        fr = 1'b1;
        send(1, 1); send(0, 0); send(0, 1); send(0, 1);
        check("s1_flit0", flit_out, 4'b1101);
        check("s1_vld0", flit_valid, 1);
        send(1, 0); send(0, 1); send(0, 1); send(0, 0);
        check("s1_flit1", flit_out, 4'b0110);
        check("s1_vld1", flit_valid, 1);
        idle();

        // Backpressure: first flit held, second parks in HOLD
        fr = 1'b0;
        send(1, 1); send(0, 1); send(0, 0); send(0, 0);
        check("s2_first", flit_out, 4'b0011);
        send(1, 1); send(0, 0); send(0, 0); send(0, 1);
        check("s2_hold_ptr", ptr, 4);
        check("s2_hold_rdy", link_ready, 0);
        send(1, 0); send(0, 1);
        check("s2_stable", flit_out, 4'b0011);
        check("s2_ignored_ptr", ptr, 4);
        fr = 1'b1;
        idle();
        fr = 1'b0;
        check("s2_second", flit_out, 4'b1001);
        check("s2_vld", flit_valid, 1);
        check("s2_ptr0", ptr, 0);
        check("s2_rdy", link_ready, 1);
        fr = 1'b1;
        idle();

        // Mid-flit sof aborts the partial flit
        send(1, 1); send(0, 0); send(1, 0);
        check("s3_err_sof", err_sof, 1);
        send(0, 1);
        check("s3_err_sof_clr", err_sof, 0);
        send(0, 1); send(0, 1);
        check("s3_flit", flit_out, 4'b1110);
        idle();

        // Bits without sof in IDLE are dropped
        send(0, 1);
        check("s4_nosof0", err_nosof, 1);
        check("s4_ptr0", ptr, 0);
        send(0, 1);
        check("s4_nosof1", err_nosof, 1);
        check("s4_ptr1", ptr, 0);
        send(1, 1); send(0, 0); send(0, 0); send(0, 0);
        check("s4_flit", flit_out, 4'b0001);
        idle();

        // Asynchronous reset while receiving with a flit held at the output
        fr = 1'b0;
        send(1, 0); send(0, 1); send(0, 0); send(0, 1);
        send(1, 1); send(0, 0);
        check("s5_pre_ptr", ptr, 2);
        check("s5_pre_vld", flit_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("s5_ptr", ptr, 0);
        check("s5_vld", flit_valid, 0);
        check("s5_out", flit_out, 0);
        check("s5_rdy", link_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fr = 1'b1;
        send(0, 1);
        send(1, 1); send(0, 0); send(0, 0); send(0, 1);
        check("s5_after", flit_out, 4'b1001);
        idle();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            lv = ($urandom_range(0, 9) < 8);
            ls = ($urandom_range(0, 3) == 0);
            lb = 1'($urandom);
            fr = ($urandom_range(0, 9) < 6);
            @(posedge clk); #1;
        end
        lv = 1'b0; fr = 1'b1;
        idle(); idle();

        // Single-bit flits
        f1r = 1'b1;
        send1(1, 1);
        check("s6_out0", o1_out, 1);
        check("s6_vld0", o1_vld, 1);
        send1(1, 0);
        check("s6_out1", o1_out, 0);
        check("s6_vld1", o1_vld, 1);
        check("s6_errs1", {o1_esof, o1_enosof}, 0);
        send1(1, 1);
        check("s6_out2", o1_out, 1);
        check("s6_vld2", o1_vld, 1);
        check("s6_errs2", {o1_esof, o1_enosof}, 0);
        check("s6_rdy", o1_rdy, 1);
        send1(0, 0);
        check("s6_nosof", o1_enosof, 1);
        check("s6_drained", o1_vld, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/inport_in_interface_ctrl.md
# inport_in_interface_ctrl

Input-port link receiver controller for the router input interface. It accepts a flit from the inter-router link one bit per cycle and tracks the fill position with an internal right-side pointer that runs 0..flit_size. It assembles the bits into a flit and presents the completed flit to the input buffer through a valid/ready handshake. It applies backpressure to the link, aborts partial flits on a misplaced start-of-flit, and drops framing-less bits.

## Interface
- flit_size, default 8: flit width in bits. Must be ≥1.
- floorplusone_log2_flit_size, default 4: pointer width. Must equal floor(log2(flit_size))+1.

- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- link_valid  in  1  link bit present this cycle.
- link_sof  in  1  qualifies link_bit as bit 0 of a new flit.
- link_bit  in  1  serial data bit.
- link_ready  out  1  controller can accept a link bit this cycle.
- flit_out  out  flit_size  assembled flit. Bit k holds the k-th received bit (LSB first).
- flit_valid  out  1  flit_out holds an unconsumed flit.
- flit_ready  in  1  input buffer accepts flit_out this cycle.
- ptr  out  floorplusone_log2_flit_size  current fill pointer (debug/visibility).
- err_sof  out  1  one-cycle pulse: a partial flit was aborted by link_sof.
- err_nosof  out  1  one-cycle pulse: a bit with no link_sof was dropped in IDLE.

## Operation
- States derived from ptr:
  - IDLE when ptr==0.
  - RECV when 0<ptr<flit_size.
  - HOLD when ptr==flit_size (assembly full, output slot busy).
- Definitions:
  - accept = link_valid & link_ready.
  - slot_free = !flit_valid | flit_ready.
- link_ready = (ptr != flit_size). It is combinational from ptr only and has no path from flit_ready.
- Accept with link_sof:
  - asm[0] <= link_bit, ptr <= 1.
  - If the state was RECV, pulse err_sof; the partial flit is discarded.
  - In IDLE there is no error.
- Accept without link_sof:
  - In IDLE: the bit is dropped, ptr stays 0, and err_nosof pulses.
  - In RECV: asm[ptr] <= link_bit, ptr <= ptr+1.
- Completion (the accepted bit is the last bit, i.e. the new ptr would equal flit_size):
  - If slot_free: flit_out <= assembled flit including this bit, flit_valid <= 1, ptr <= 0. No bubble.
  - Otherwise: ptr <= flit_size (HOLD).
- flit_size==1: every accepted link_sof bit completes a flit immediately.
- HOLD: when slot_free, flit_out <= asm, flit_valid <= 1, ptr <= 0. No link bits are accepted in HOLD.
- Handshake on the output side:
  - flit_valid clears when flit_valid & flit_ready and no transfer occurs the same cycle.
  - A same-cycle drain and load leaves flit_valid at 1 with the new data.
  - flit_out and flit_valid are stable while flit_valid & !flit_ready.
- Reset (any time, including mid-flit or in HOLD):
  - ptr=0, asm=0, flit_out=0, flit_valid=0, err_sof=0, err_nosof=0, therefore link_ready=1.
  - Any partial or held flit is lost.
  - After reset the first accepted bit must carry link_sof or it is dropped.

## Timing
- All outputs except link_ready are registered.
- Latency: flit_valid rises on the edge that accepts the last bit when the output slot is free. flit_out is visible the following cycle.
- Throughput: 1 flit per flit_size cycles with flit_ready held high.
- HOLD exit: one cycle after slot_free. link_ready rises in the cycle after the transfer.
- err_sof and err_nosof are high for exactly the cycle after the offending accept.
- No X on any output after reset deassertion. The pointer never exceeds flit_size.

## Test plan
All scenarios use flit_size=4 and floorplusone_log2_flit_size=3 unless stated.
1. Back-to-back flits, flit_ready=1:
   - Stimulus: bits 1,0,1,1 (sof on the first), then 0,1,1,0 (sof on the first), continuous.
   - Required: flit_out=4'b1101 then 4'b0110. flit_valid high in the cycle after each 4th bit. link_ready never drops. Zero bubbles.
2. Backpressure:
   - Stimulus: flit_ready=0; send two full flits.
   - Required:
     - The first flit is held with flit_out stable.
     - After the second flit's 4th bit, ptr=4 and link_ready=0; further link_valid is ignored.
     - Raise flit_ready for 1 cycle: the second flit appears next cycle, flit_valid stays 1, ptr=0, link_ready=1.
3. Mid-flit sof abort:
   - Stimulus: sof+1, 0, then sof+0, 1, 1, 1.
   - Required: err_sof pulses once after the second sof. The resulting flit_out=4'b1110.
4. No-sof drop:
   - Stimulus: from IDLE, bits 1,1 without sof, then sof+1, 0, 0, 0.
   - Required: err_nosof pulses twice, ptr stays 0 across the dropped bits, flit_out=4'b0001.
5. Async reset mid-operation:
   - Stimulus: assert rst low between clock edges in RECV (ptr=2) with flit_valid=1.
   - Required: immediately ptr=0, flit_valid=0, flit_out=0, link_ready=1. After release, a new sof flit assembles correctly.
6. flit_size=1, floorplusone_log2_flit_size=1:
   - Stimulus: sof+1, sof+0, sof+1 on consecutive cycles with flit_ready=1.
   - Required: flit_out sequence 1,0,1 with flit_valid continuously high, and no errors.
